// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage load/store unit.
//
// Takes the registered EX/MEM fields (address, store data, write flag, result
// select, funct3) and runs one data-memory transaction over a ready/valid bus.
// Stores are lane-replicated with byte strobes. Loads are aligned and sign- or
// zero-extended. StallM holds the upstream pipeline while an access is in flight.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   ALUResultM        effective byte address
//   WriteDataM        store data (rs2)
//   MemWriteM         store present
//   ResultSrcM        2'b01 marks a load
//   funct3M           access size / signedness
//   ReadDataM         formatted load data, valid only in the completion cycle
//   StallM            hold IF/ID/EX/MEM this cycle
//   MisalignM         misaligned access; no bus access is made
//   mem_req/mem_we    bus request / write enable
//   mem_addr          word-aligned bus address
//   mem_wdata         lane-replicated store data
//   mem_wstrb         byte strobes, 0 on reads
//   mem_ready         request accepted while mem_req=1
//   mem_rvalid        read data valid
//   mem_rdata         read word
module mem_access_stage #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] ALUResultM,
   input  logic [DATA_WIDTH-1:0] WriteDataM,
   input  logic                  MemWriteM,
   input  logic [1:0]            ResultSrcM,
   input  logic [2:0]            funct3M,
   output logic [DATA_WIDTH-1:0] ReadDataM,
   output logic                  StallM,
   output logic                  MisalignM,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_wstrb,
   input  logic                  mem_ready,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] addr_q, wdata_q, rdata_q;
   logic [3:0]            wstrb_q;
   logic                  we_q;
   logic [2:0]            f3_q;
   logic [1:0]            off_q;

   // Decode of the instruction currently presented in MEM
   logic                  is_store, is_load, legal, misaligned, start;
   logic [1:0]            off;
   logic [DATA_WIDTH-1:0] fmt_wdata;
   logic [3:0]            fmt_wstrb;
   logic [DATA_WIDTH-1:0] lane_word, load_fmt;

   always_comb begin
      is_store   = MemWriteM;
      is_load    = !MemWriteM && (ResultSrcM == 2'b01);
      off        = ALUResultM[1:0];
      legal      = 1'b0;
      misaligned = 1'b0;
      if (is_store) begin
         legal = (funct3M == 3'b000) || (funct3M == 3'b001) || (funct3M == 3'b010);
      end else if (is_load) begin
         legal = (funct3M == 3'b000) || (funct3M == 3'b001) || (funct3M == 3'b010) ||
                 (funct3M == 3'b100) || (funct3M == 3'b101);
      end
      if (legal) begin
         misaligned = ((funct3M[1:0] == 2'b01) && off[0]) ||
                      ((funct3M[1:0] == 2'b10) && (off != 2'b00));
      end
      start = legal && !misaligned;
   end

   // Store formatting: replicate data across lanes, strobe only the addressed bytes
   always_comb begin
      fmt_wdata = WriteDataM;
      fmt_wstrb = 4'b1111;
      unique case (funct3M[1:0])
         2'b00: begin
            fmt_wdata = {4{WriteDataM[7:0]}};
            fmt_wstrb = 4'b0001 << off;
         end
         2'b01: begin
            fmt_wdata = {2{WriteDataM[15:0]}};
            fmt_wstrb = 4'b0011 << off;
         end
         default: begin
            fmt_wdata = WriteDataM;
            fmt_wstrb = 4'b1111;
         end
      endcase
   end

   // Load formatting from the captured word
   always_comb begin
      lane_word = rdata_q >> {off_q, 3'b000};
      load_fmt  = lane_word;
      unique case (f3_q)
         3'b000:  load_fmt = {{24{lane_word[7]}}, lane_word[7:0]};
         3'b001:  load_fmt = {{16{lane_word[15]}}, lane_word[15:0]};
         3'b100:  load_fmt = {24'd0, lane_word[7:0]};
         3'b101:  load_fmt = {16'd0, lane_word[15:0]};
         default: load_fmt = rdata_q;
      endcase
   end

   // Next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (start) state_d = StReq;
         StReq:  if (mem_ready) state_d = we_q ? StDone : StResp;
         StResp: if (mem_rvalid) state_d = StDone;
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         we_q    <= 1'b0;
         f3_q    <= '0;
         off_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         // Bus fields are captured once on entry so they stay stable through REQ
         if (state_q == StIdle && start) begin
            addr_q  <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
            wdata_q <= fmt_wdata;
            wstrb_q <= is_store ? fmt_wstrb : 4'b0000;
            we_q    <= is_store;
            f3_q    <= funct3M;
            off_q   <= off;
         end
         if (state_q == StResp && mem_rvalid) begin
            rdata_q <= mem_rdata;
         end
      end
   end

   // Outputs; combinational terms are gated so everything reads 0 while in reset
   always_comb begin
      StallM    = 1'b0;
      MisalignM = 1'b0;
      ReadDataM = '0;
      if (!rst) begin
         unique case (state_q)
            StIdle: begin
               StallM    = start;
               MisalignM = legal && misaligned;
            end
            StReq, StResp: StallM = 1'b1;
            StDone: if (!we_q) ReadDataM = load_fmt;
            default: StallM = 1'b0;
         endcase
      end
   end

   assign mem_req   = (state_q == StReq);
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed test-plan cases with literal pins, a
// mid-transaction reset, then randomized accesses against a behavioural model.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ALUResultM, WriteDataM;
   logic        MemWriteM;
   logic [1:0]  ResultSrcM;
   logic [2:0]  funct3M;
   logic [31:0] ReadDataM;
   logic        StallM, MisalignM;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready, mem_rvalid;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   mem_access_stage #(.DATA_WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .MemWriteM  (MemWriteM),
      .ResultSrcM (ResultSrcM),
      .funct3M    (funct3M),
      .ReadDataM  (ReadDataM),
      .StallM     (StallM),
      .MisalignM  (MisalignM),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_ready  (mem_ready),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   int total = 0;
   int bad   = 0;

   // Per-cycle expectations, written by the driver and read by the compare process
   logic        chk_en = 1'b0;
   logic        exp_stall, exp_req, exp_mis, exp_we, exp_done, exp_zero;
   logic [31:0] exp_rd, exp_addr, exp_wdata;
   logic [3:0]  exp_wstrb;

   // Observations for the literal pins
   int          cnt_stall, cnt_req, cnt_mis;
   logic [31:0] seen_rd, seen_addr, seen_wdata;
   logic [3:0]  seen_wstrb;
   logic        seen_we;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic bit m_legal(input bit st, input logic [2:0] f);
      if (st) return (f == 3'd0) || (f == 3'd1) || (f == 3'd2);
      return !((f == 3'd3) || (f == 3'd6) || (f == 3'd7));
   endfunction

   function automatic int m_size(input logic [2:0] f);
      return 1 << f[1:0];
   endfunction

   function automatic bit m_mis(input logic [31:0] a, input logic [2:0] f);
      return (a % m_size(f)) != 0;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [2:0] f);
      int sz;
      sz = m_size(f);
      if (sz == 1) return wd[7:0] * 32'h0101_0101;
      if (sz == 2) return wd[15:0] * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [3:0] m_wstrb(input logic [31:0] a, input logic [2:0] f);
      logic [7:0] s;
      s = ((8'd1 << m_size(f)) - 8'd1) << (a % 4);
      return s[3:0];
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a,
                                          input logic [2:0] f);
      int          sz;
      logic [31:0] v, mask;
      sz = m_size(f);
      v  = w >> (8 * (a % 4));
      if (sz == 4) return v;
      mask = (32'd1 << (8 * sz)) - 32'd1;
      v    = v & mask;
      if (!f[2] && v[8*sz-1]) v = v | ~mask;
      return v;
   endfunction

   // ---------------- compare process ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("stall", {31'd0, StallM}, {31'd0, exp_stall});
            chk("req", {31'd0, mem_req}, {31'd0, exp_req});
            chk("misalign", {31'd0, MisalignM}, {31'd0, exp_mis});
            chk("rdata", ReadDataM, exp_rd);
            if (exp_req) begin
               chk("addr", mem_addr, exp_addr);
               chk("we", {31'd0, mem_we}, {31'd0, exp_we});
               chk("wstrb", {28'd0, mem_wstrb}, {28'd0, exp_wstrb});
               if (exp_we) chk("wdata", mem_wdata, exp_wdata);
            end
            if (exp_zero) begin
               chk("rst_addr", mem_addr, 32'd0);
               chk("rst_wdata", mem_wdata, 32'd0);
               chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
               chk("rst_we", {31'd0, mem_we}, 32'd0);
            end
            if (StallM) cnt_stall++;
            if (MisalignM) cnt_mis++;
            if (mem_req) begin
               cnt_req++;
               seen_addr  = mem_addr;
               seen_wdata = mem_wdata;
               seen_wstrb = mem_wstrb;
               seen_we    = mem_we;
            end
            if (exp_done) seen_rd = ReadDataM;
         end
      end
   end

   task automatic clear_obs();
      cnt_stall = 0;
      cnt_req   = 0;
      cnt_mis   = 0;
      seen_rd   = 'x;
   endtask

   task automatic set_idle_exp();
      exp_stall = 1'b0;
      exp_req   = 1'b0;
      exp_mis   = 1'b0;
      exp_rd    = 32'd0;
      exp_done  = 1'b0;
      exp_we    = 1'b0;
      exp_addr  = 32'd0;
      exp_wdata = 32'd0;
      exp_wstrb = 4'd0;
   endtask

   // One instruction held in MEM for as long as the model says it stalls.
   // r = REQ cycles with ready low, v = RESP cycles with rvalid low.
   task automatic run_instr(input logic [31:0] a, input logic [31:0] wd, input bit mw,
                            input logic [1:0] rs, input logic [2:0] f, input int r,
                            input int v, input logic [31:0] word);
      bit st, ld, ok, mis, go;
      int n;
      st  = mw;
      ld  = !mw && (rs == 2'b01);
      ok  = (st || ld) && m_legal(st, f);
      mis = ok && m_mis(a, f);
      go  = ok && !mis;
      n   = !go ? 1 : (st ? r + 3 : r + v + 4);
      clear_obs();
      for (int k = 0; k < n; k++) begin
         ALUResultM = a;
         WriteDataM = wd;
         MemWriteM  = mw;
         ResultSrcM = rs;
         funct3M    = f;
         // Upstream glitches while stalled must not reach the bus
         if (k > 0 && k < n - 1 && $urandom_range(0, 3) == 0) begin
            ALUResultM = $urandom;
            WriteDataM = $urandom;
         end
         mem_ready  = 1'($urandom_range(0, 1));
         mem_rvalid = 1'($urandom_range(0, 1));
         mem_rdata  = $urandom;
         if (go) begin
            if (k >= 1 && k <= r) mem_ready = 1'b0;
            if (k == r + 1) mem_ready = 1'b1;
            if (ld) begin
               if (k >= r + 2 && k < r + 2 + v) mem_rvalid = 1'b0;
               if (k == r + 2 + v) begin
                  mem_rvalid = 1'b1;
                  mem_rdata  = word;
               end
            end
         end
         exp_stall = go && (k < n - 1);
         exp_req   = go && (k >= 1) && (k <= r + 1);
         exp_mis   = mis && (k == 0);
         exp_done  = go && (k == n - 1);
         exp_rd    = (go && ld && k == n - 1) ? m_load(word, a, f) : 32'd0;
         exp_addr  = {a[31:2], 2'b00};
         exp_we    = st;
         exp_wstrb = st ? m_wstrb(a, f) : 4'd0;
         exp_wdata = m_wdata(wd, f);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [31:0] a, wd, w;
      bit          mw;
      logic [1:0]  rs;
      logic [2:0]  f;

      // Reset with a legal load presented: all outputs must still read 0
      rst        = 1'b1;
      ALUResultM = 32'h0000_5000;
      WriteDataM = 32'd0;
      MemWriteM  = 1'b0;
      ResultSrcM = 2'b01;
      funct3M    = 3'b010;
      mem_ready  = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1234_5678;
      set_idle_exp();
      exp_zero = 1'b1;
      chk_en   = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst      = 1'b0;
      exp_zero = 1'b0;

      // SB at 0x1003
      run_instr(32'h1003, 32'h0000_00A5, 1'b1, 2'b00, 3'b000, 0, 0, 32'd0);
      chk("sb_addr", seen_addr, 32'h0000_1000);
      chk("sb_wdata", seen_wdata, 32'hA5A5_A5A5);
      chk("sb_wstrb", {28'd0, seen_wstrb}, 32'h8);
      chk("sb_we", {31'd0, seen_we}, 32'd1);
      chk("sb_stall_cycles", cnt_stall, 2);

      // LB then LBU at 0x2001 with two RESP waits
      run_instr(32'h2001, 32'd0, 1'b0, 2'b01, 3'b000, 0, 2, 32'h0000_80FF);
      chk("lb_data", seen_rd, 32'hFFFF_FF80);
      chk("lb_stall_cycles", cnt_stall, 5);
      run_instr(32'h2001, 32'd0, 1'b0, 2'b01, 3'b100, 0, 2, 32'h0000_80FF);
      chk("lbu_data", seen_rd, 32'h0000_0080);
      chk("lbu_stall_cycles", cnt_stall, 5);

      // LW with ready held low three cycles
      run_instr(32'h3000, 32'd0, 1'b0, 2'b01, 3'b010, 3, 0, 32'hDEAD_BEEF);
      chk("lw_data", seen_rd, 32'hDEAD_BEEF);
      chk("lw_addr", seen_addr, 32'h0000_3000);
      chk("lw_req_cycles", cnt_req, 4);

      // Misaligned LH and SW
      run_instr(32'h4001, 32'd0, 1'b0, 2'b01, 3'b001, 0, 0, 32'd0);
      chk("lh_mis_flag", cnt_mis, 1);
      chk("lh_mis_req", cnt_req, 0);
      chk("lh_mis_stall", cnt_stall, 0);
      run_instr(32'h4002, 32'h1111_2222, 1'b1, 2'b00, 3'b010, 0, 0, 32'd0);
      chk("sw_mis_flag", cnt_mis, 1);
      chk("sw_mis_req", cnt_req, 0);
      chk("sw_mis_stall", cnt_stall, 0);

      // Non-access instructions with rvalid/ready noise
      clear_obs();
      for (int i = 0; i < 6; i++) begin
         run_instr($urandom, $urandom, 1'b0, 2'b00, 3'b010, 0, 0, 32'd0);
      end
      chk("noacc_stall", cnt_stall, 0);

      // Reset while waiting in RESP, followed by rvalid
      clear_obs();
      run_instr(32'h5000, 32'd0, 1'b0, 2'b01, 3'b010, 0, 5, 32'hCAFE_F00D);
      // the load above completed; now start one and cut it off in RESP
      ALUResultM = 32'h6004;
      MemWriteM  = 1'b0;
      ResultSrcM = 2'b01;
      funct3M    = 3'b010;
      mem_rvalid = 1'b0;
      mem_ready  = 1'b0;
      set_idle_exp();
      exp_stall = 1'b1;
      @(posedge clk);
      #1;
      mem_ready = 1'b1;
      exp_req   = 1'b1;
      exp_addr  = 32'h6004;
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      exp_req   = 1'b0;
      @(posedge clk);
      #1;
      clear_obs();
      rst        = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBAD0_BAD0;
      set_idle_exp();
      exp_zero = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst        = 1'b0;
      MemWriteM  = 1'b0;
      ResultSrcM = 2'b00;
      mem_ready  = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      exp_zero = 1'b0;
      chk("rst_stall_cycles", cnt_stall, 0);
      chk("rst_req_cycles", cnt_req, 0);

      // Randomized accesses
      for (int i = 0; i < 300; i++) begin
         a  = $urandom;
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
         wd = $urandom;
         w  = $urandom;
         mw = ($urandom_range(0, 2) == 0);
         rs = ($urandom_range(0, 3) != 0) ? 2'b01 : 2'($urandom_range(0, 3));
         f  = 3'($urandom_range(0, 7));
         run_instr(a, wd, mw, rs, f, $urandom_range(0, 3), $urandom_range(0, 3), w);
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-stage load/store unit sitting directly downstream of the EX/MEM pipeline register. It consumes the registered ALU result, store data, memory-write flag, result-select and funct3, and performs the corresponding data-memory transaction over a ready/valid bus. Byte and halfword stores are formatted with lane strobes; loads are aligned and sign- or zero-extended. It drives a stall to the hazard unit while a transaction is outstanding, so the pipeline holds the instruction in MEM until the access completes.

## Interface
- DATA_WIDTH, 32, data and address width; only 32 is supported.
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ALUResultM  input  32  effective byte address from EX/MEM.
- WriteDataM  input  32  store data (rs2) from EX/MEM.
- MemWriteM  input  1  store instruction in MEM.
- ResultSrcM  input  2  2'b01 marks a load.
- funct3M  input  3  access size/sign.
- ReadDataM  output  32  formatted load data to MEM/WB.
- StallM  output  1  hold IF/ID/EX/MEM registers this cycle.
- MisalignM  output  1  misaligned access flag; no bus access made.
- mem_req  output  1  bus request.
- mem_we  output  1  1 = write, 0 = read.
- mem_addr  output  32  word address, low two bits always 0.
- mem_wdata  output  32  lane-replicated store data.
- mem_wstrb  output  4  byte-lane write strobes; 0 on reads.
- mem_ready  input  1  request accepted this cycle when mem_req=1.
- mem_rvalid  input  1  read data valid.
- mem_rdata  input  32  read word.

## Operation
- Access present: MemWriteM=1 (store) or ResultSrcM=2'b01 (load); store takes priority if both are set.
- Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Any other value is a no-op: no stall, no flag, ReadDataM=0.
- Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0. In that case MisalignM=1 combinationally, there is no bus access, StallM=0 and ReadDataM=0.
- Store formatting:
  - SB: wdata={4{WriteDataM[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{WriteDataM[15:0]}}, wstrb=4'b0011<<addr[1:0].
  - SW: wdata=WriteDataM, wstrb=4'b1111.
- Load formatting: select the byte/half at addr[1:0] from the captured word; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- FSM states:
  - IDLE: a legal aligned access asserts StallM combinationally; mem_addr/mem_wdata/mem_wstrb/mem_we/size/offset are registered and the FSM goes to REQ. Otherwise it stays in IDLE.
  - REQ: mem_req=1, StallM=1, bus outputs held stable. When mem_ready=1, a store goes to DONE and a load goes to RESP.
  - RESP: mem_req=0, StallM=1. When mem_rvalid=1, mem_rdata is captured and the FSM goes to DONE.
  - DONE: StallM=0 and ReadDataM is driven from the captured, formatted data; the pipeline advances at this edge. The FSM goes to IDLE unconditionally.
- mem_rvalid outside RESP is ignored. mem_ready outside REQ is ignored.
- ReadDataM is 0 in every state except DONE-after-load.

## Timing
- Reset (async, immediate):
  - state=IDLE; captured data and registered bus fields are cleared to 0.
  - While rst=1, all outputs are 0, including StallM and MisalignM.
- Reset mid-transaction: mem_req drops in the same cycle, and any later mem_ready/mem_rvalid is discarded.
- Store, mem_ready=1 on the first REQ cycle: IDLE→REQ→DONE. That is 3 cycles in MEM with StallM high for 2.
- Load, ready and rvalid each asserted on the earliest cycle: IDLE→REQ→RESP→DONE. That is 4 cycles with StallM high for 3.
- Each cycle mem_ready stays low adds one REQ cycle. Each cycle mem_rvalid stays low adds one RESP cycle.
- Bus outputs are registered and do not change while in REQ, even if the inputs glitch.
- StallM is combinational from state and inputs only in IDLE; in all other states it is a function of state alone.
- Back-to-back accesses: a new instruction arriving in the cycle after DONE starts a fresh IDLE→REQ sequence with no bubble.

## Test plan
- SB: addr=0x1003, data=0xA5, ready in first REQ cycle → mem_addr=0x1000, wdata=0xA5A5A5A5, wstrb=4'b1000, we=1; StallM high 2 cycles.
- LB then LBU: addr=0x2001, rdata=0x0000_80FF, ready=1, rvalid after 2 RESP waits → ReadDataM=0xFFFFFF80 for LB, then 0x00000080 for LBU; StallM high 5 cycles each.
- LW: addr=0x3000, ready held low 3 cycles → mem_req held with stable addr 0x3000; rdata=0xDEADBEEF → ReadDataM=0xDEADBEEF in DONE.
- Misaligned: LH at 0x4001 and SW at 0x4002 → MisalignM=1, mem_req never asserts, StallM=0.
- Reset: rst asserted during RESP, then rvalid=1 → mem_req=0 and StallM=0 immediately; state=IDLE; ReadDataM stays 0.
- Non-access instruction (ResultSrcM=00, MemWriteM=0) with mem_rvalid pulses → no stall, no request, ReadDataM=0.
